apb_regfile_ws: RTL and testbench
=================================

Name: apb_regfile_ws

Overview:
- Parametrised APB3 slave with an internal DEPTH x DATA_W register file and programmable read/write wait states.
- Generalises the fixed 8-bit, fixed-wait register wrapper: adds configurable width and depth, separate read/write wait counts, an out-of-range error response, and optional byte strobes.
- Sits on the FIC APB bus behind the interconnect, as a scratch/config register bank.

Parameters:
- DATA_W, 32, data width in bits; multiple of 8.
- ADDR_W, 8, PADDR width; constraint DEPTH <= 2**ADDR_W.
- DEPTH, 16, number of words; word index = PADDR (word addressing, no byte offset).
- RD_WAIT, 2, PREADY-low cycles inserted in a read access phase; 0..15.
- WR_WAIT, 0, PREADY-low cycles inserted in a write access phase; 0..15.

Ports:
- PCLK  in  1  APB clock; all logic on rising edge.
- PRESETN  in  1  reset, asynchronous, active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  word index.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data, registered.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response, valid when PREADY=1.

Behaviour:
- Reset (async, PRESETN=0):
  - state IDLE, wait counter 0.
  - PRDATA=0, PREADY=1, PSLVERR=0.
  - all register-file words cleared to 0.
- FSM states:
  - IDLE -> WAIT on a setup cycle (PSEL=1, PENABLE=0). At that edge: capture PADDR, PWRITE, PWDATA; load counter with RD_WAIT or WR_WAIT; compute err_q = (PADDR >= DEPTH).
  - WAIT: counter decrements each cycle while nonzero. When it reaches 0, go to READY.
  - If the loaded wait count is 0, go directly IDLE -> READY.
  - READY: PREADY=1. The transfer completes at the edge where PSEL & PENABLE & PREADY; state returns to IDLE at that edge.
- PREADY:
  - 0 in WAIT.
  - 1 in IDLE and READY.
  - Driven combinationally from registered state only; no input-to-output path.
- Latency:
  - Access phase lasts 1 + RD_WAIT (read) or 1 + WR_WAIT (write) cycles.
  - Zero-wait transfers take 2 cycles total (setup + access).
- Write:
  - The register file updates at the completing edge, only if err_q=0.
  - Out-of-range writes are discarded.
- Read:
  - PRDATA is loaded with mem[addr_q] on entry to READY (0 if err_q), and holds until the next read's load.
  - Writes never change PRDATA.
- PSLVERR:
  - Equals err_q in READY; 0 otherwise.
  - Returns to 0 after completion.
- Back-to-back transfers: a new setup cycle in the cycle after completion is accepted normally; no dead cycle is required.
- Read after write to the same address returns the new data.
- PSEL deasserted while in WAIT or READY (protocol violation): abort to IDLE next edge, no write, PRDATA unchanged.
- PRESETN asserted mid-transfer: immediate return to the reset state; the in-flight write is lost.
- Inputs in IDLE without a setup cycle are ignored.

Optional Feature:
- Macro: APB_REGFILE_PSTRB_EN.
- Defined:
  - Adds input PSTRB, width DATA_W/8 (APB4 byte strobes), captured at setup.
  - On write, byte lane i is updated only if PSTRB[i]=1.
  - Reads ignore PSTRB.
  - PSTRB=0 on a write is legal: no change, PSLVERR follows the address check only.
- Undefined:
  - No PSTRB port; every write updates the full word.

Test Plan:
- Reset: release PRESETN -> PRDATA=0, PREADY=1, PSLVERR=0; read index 3 returns 0x00000000.
- Write and read with WR_WAIT=0, RD_WAIT=2:
  - write 0xDEADBEEF to index 5 -> PREADY high in the first access cycle.
  - read index 5 -> PREADY low for exactly 2 access cycles, then PRDATA=0xDEADBEEF, PSLVERR=0.
- Out of range (DEPTH=16): write 0x12345678 to index 16 -> PSLVERR=1 at completion; read index 16 -> PRDATA=0, PSLVERR=1; indices 0..15 unchanged.
- Back-to-back: write index 0 = 0x1, write index 15 = 0xF, read index 0, read index 15 with no idle cycles -> returns 0x1, 0xF; no lost transfers.
- Mid-operation:
  - Assert PRESETN during a read wait -> outputs return to reset values immediately.
  - Drop PSEL during a write wait -> target word unchanged, FSM back in IDLE.
- With APB_REGFILE_PSTRB_EN: index 2 = 0xAABBCCDD, write 0x11223344 with PSTRB=4'b0101 -> read index 2 returns 0xAA22CC44.

Source files
------------

// File: rtl/apb_regfile_ws_if.sv
// APB3 bus bundle for apb_regfile_ws; APB_REGFILE_PSTRB_EN adds APB4 byte strobes.
interface apb_regfile_ws_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;
`ifdef APB_REGFILE_PSTRB_EN
    logic [DATA_W/8-1:0] PSTRB;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );
    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
`else
    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );
    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
`endif
endinterface

// File: rtl/apb_regfile_ws.sv
// APB3 slave register file (DEPTH x DATA_W) with separate read/write wait states.
// Optional macro APB_REGFILE_PSTRB_EN enables per-byte write strobes.
module apb_regfile_ws #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned RD_WAIT = 2,
    parameter int unsigned WR_WAIT = 0
) (
    input logic              PCLK,
    input logic              PRESETN,
    apb_regfile_ws_if.slave  apb
);
    localparam int unsigned     IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     NB        = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      RD_WAIT_L = 4'(RD_WAIT);
    localparam logic [3:0]      WR_WAIT_L = 4'(WR_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
`ifdef APB_REGFILE_PSTRB_EN
    logic [NB-1:0]     strb_q, strb_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        prdata_d = prdata_q;
        mem_d    = mem_q;
`ifdef APB_REGFILE_PSTRB_EN
        strb_d   = strb_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (apb.PSEL && !apb.PENABLE) begin
                    addr_d  = apb.PADDR[IDX_W-1:0];
                    write_d = apb.PWRITE;
                    wdata_d = apb.PWDATA;
                    err_d   = ({1'b0, apb.PADDR} >= DEPTH_L);
                    cnt_d   = apb.PWRITE ? WR_WAIT_L : RD_WAIT_L;
`ifdef APB_REGFILE_PSTRB_EN
                    strb_d  = apb.PSTRB;
`endif
                    // Zero-wait reads load PRDATA straight from the setup-cycle address.
                    if (cnt_d == 4'd0) begin
                        state_d = ST_READY;
                        if (!apb.PWRITE)
                            prdata_d = err_d ? '0 : mem_q[addr_d];
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_READY;
                        if (!write_q)
                            prdata_d = err_q ? '0 : mem_q[addr_q];
                    end
                end
            end
            ST_READY: begin
                if (!apb.PSEL) begin
                    state_d = ST_IDLE;
                end else if (apb.PENABLE) begin
                    state_d = ST_IDLE;
                    if (write_q && !err_q) begin
                        for (int unsigned b = 0; b < NB; b++) begin
`ifdef APB_REGFILE_PSTRB_EN
                            if (strb_q[b])
                                mem_d[addr_q][8*b +: 8] = wdata_q[8*b +: 8];
`else
                            mem_d[addr_q][8*b +: 8] = wdata_q[8*b +: 8];
`endif
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            prdata_q <= '0;
            mem_q    <= '{default: '0};
`ifdef APB_REGFILE_PSTRB_EN
            strb_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            err_q    <= err_d;
            wdata_q  <= wdata_d;
            prdata_q <= prdata_d;
            mem_q    <= mem_d;
`ifdef APB_REGFILE_PSTRB_EN
            strb_q   <= strb_d;
`endif
        end
    end

    assign apb.PREADY  = (state_q != ST_WAIT);
    assign apb.PSLVERR = (state_q == ST_READY) && err_q;
    assign apb.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_regfile_ws.sv
// Scoreboard bench for apb_regfile_ws: expected completions queued at setup, checked at PREADY.
module tb_apb_regfile_ws;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned RD_WAIT = 2;
    localparam int unsigned WR_WAIT = 0;

    logic PCLK = 1'b0;
    logic PRESETN = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_regfile_ws_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    apb_regfile_ws #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_WAIT(RD_WAIT),
        .WR_WAIT(WR_WAIT)
    ) dut (
        .PCLK   (PCLK),
        .PRESETN(PRESETN),
        .apb    (apb.slave)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] model_prdata;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] rd;

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        model_prdata = '0;
    endtask

    task automatic apb_idle();
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;
`ifdef APB_REGFILE_PSTRB_EN
        apb.PSTRB   = '0;
`endif
    endtask

    // Called just after a rising edge; returns just after the completing edge.
    task automatic xfer(input string tag, input logic wr, input int unsigned addr,
                        input logic [31:0] wdata, input logic [3:0] strb,
                        output logic [31:0] rdata);
        exp_t        e;
        exp_t        got;
        int          waits;
        logic        timed_out;
        logic [3:0]  strb_eff;
`ifdef APB_REGFILE_PSTRB_EN
        strb_eff = strb;
`else
        strb_eff = 4'hF;
`endif
        e.err   = (addr >= DEPTH);
        e.waits = wr ? int'(WR_WAIT) : int'(RD_WAIT);
        if (wr) begin
            if (!e.err)
                for (int b = 0; b < 4; b++)
                    if (strb_eff[b]) model[addr][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            model_prdata = e.err ? 32'h0 : model[addr];
        end
        e.rdata = model_prdata;
        sb.push_back(e);

        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = wr;
        apb.PADDR   = addr[ADDR_W-1:0];
        apb.PWDATA  = wdata;
`ifdef APB_REGFILE_PSTRB_EN
        apb.PSTRB   = strb;
`endif
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        waits = 0;
        timed_out = 1'b0;
        forever begin
            @(negedge PCLK);
            if (apb.PREADY === 1'b1) break;
            waits++;
            if (waits > 40) begin
                timed_out = 1'b1;
                break;
            end
        end
        got = sb.pop_front();
        checks++;
        if (timed_out) begin
            failures++;
            $display("FAIL %s timeout: PREADY never high after %0d cycles", tag, waits);
        end
        checks++;
        if (waits !== got.waits) begin
            failures++;
            $display("FAIL %s waits got=%0d exp=%0d", tag, waits, got.waits);
        end
        checks++;
        if (apb.PSLVERR !== got.err) begin
            failures++;
            $display("FAIL %s pslverr got=%b exp=%b", tag, apb.PSLVERR, got.err);
        end
        checks++;
        if (apb.PRDATA !== got.rdata) begin
            failures++;
            $display("FAIL %s prdata got=%h exp=%h", tag, apb.PRDATA, got.rdata);
        end
        rdata = apb.PRDATA;
        @(posedge PCLK); #1;
        apb_idle();
        checks++;
        if (apb.PSLVERR !== 1'b0 || apb.PREADY !== 1'b1) begin
            failures++;
            $display("FAIL %s post_complete pready=%b pslverr=%b exp pready=1 pslverr=0",
                     tag, apb.PREADY, apb.PSLVERR);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input logic [31:0] exp_rdata);
        checks++;
        if (apb.PRDATA !== exp_rdata || apb.PREADY !== 1'b1 || apb.PSLVERR !== 1'b0) begin
            failures++;
            $display("FAIL %s prdata=%h pready=%b pslverr=%b exp prdata=%h pready=1 pslverr=0",
                     tag, apb.PRDATA, apb.PREADY, apb.PSLVERR, exp_rdata);
        end
    endtask

    task automatic test_reset();
        apb_idle();
        model_reset();
        PRESETN = 1'b0;
        #12;
        check_idle_outputs("reset_held", 32'h0);
        @(negedge PCLK) PRESETN = 1'b1;
        @(posedge PCLK); #1;
        check_idle_outputs("reset_released", 32'h0);
        xfer("reset_rd3", 1'b0, 3, 32'h0, 4'hF, rd);
    endtask

    task automatic test_write_read();
        xfer("wr5", 1'b1, 5, 32'hDEADBEEF, 4'hF, rd);
        xfer("rd5", 1'b0, 5, 32'h0, 4'hF, rd);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd5_value got=%h exp=deadbeef", rd);
        end
    endtask

    task automatic test_out_of_range();
        xfer("wr16_oor", 1'b1, 16, 32'h12345678, 4'hF, rd);
        xfer("rd16_oor", 1'b0, 16, 32'h0, 4'hF, rd);
        for (int unsigned i = 0; i < DEPTH; i++)
            xfer("oor_scan", 1'b0, i, 32'h0, 4'hF, rd);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r0, r15;
        xfer("b2b_wr0", 1'b1, 0, 32'h1, 4'hF, rd);
        xfer("b2b_wr15", 1'b1, 15, 32'hF, 4'hF, rd);
        xfer("b2b_rd0", 1'b0, 0, 32'h0, 4'hF, r0);
        xfer("b2b_rd15", 1'b0, 15, 32'h0, 4'hF, r15);
        checks++;
        if (r0 !== 32'h1 || r15 !== 32'hF) begin
            failures++;
            $display("FAIL b2b_values got=%h,%h exp=00000001,0000000f", r0, r15);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_sb_empty got=%0d exp=0", sb.size());
        end
    endtask

    task automatic test_mid_reset();
        xfer("mr_wr9", 1'b1, 9, 32'h55AA55AA, 4'hF, rd);
        xfer("mr_rd9", 1'b0, 9, 32'h0, 4'hF, rd);
        apb.PSEL   = 1'b1;
        apb.PWRITE = 1'b0;
        apb.PADDR  = 8'd9;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(negedge PCLK);
        checks++;
        if (apb.PREADY !== 1'b0 || apb.PRDATA !== 32'h55AA55AA) begin
            failures++;
            $display("FAIL mr_in_wait pready=%b prdata=%h exp pready=0 prdata=55aa55aa",
                     apb.PREADY, apb.PRDATA);
        end
        PRESETN = 1'b0;
        #1;
        check_idle_outputs("mr_async", 32'h0);
        model_reset();
        apb_idle();
        @(negedge PCLK) PRESETN = 1'b1;
        @(posedge PCLK); #1;
        xfer("mr_rd9_after", 1'b0, 9, 32'h0, 4'hF, rd);
    endtask

    task automatic test_psel_drop();
        xfer("pd_wr7", 1'b1, 7, 32'h00000077, 4'hF, rd);
        // Write aborted in its access phase: the word must keep 0x77.
        apb.PSEL   = 1'b1;
        apb.PWRITE = 1'b1;
        apb.PADDR  = 8'd7;
        apb.PWDATA = 32'h0BAD0BAD;
`ifdef APB_REGFILE_PSTRB_EN
        apb.PSTRB  = 4'hF;
`endif
        @(posedge PCLK); #1;
        apb_idle();
        @(posedge PCLK); #1;
        check_idle_outputs("pd_wr_abort", model_prdata);
        xfer("pd_rd7", 1'b0, 7, 32'h0, 4'hF, rd);
        // Read aborted in a wait cycle: PRDATA must hold the previous read.
        apb.PSEL   = 1'b1;
        apb.PWRITE = 1'b0;
        apb.PADDR  = 8'd5;
        @(posedge PCLK); #1;
        apb.PENABLE = 1'b1;
        @(posedge PCLK); #1;
        apb_idle();
        @(posedge PCLK); #1;
        check_idle_outputs("pd_rd_abort", model_prdata);
        xfer("pd_rd0", 1'b0, 0, 32'h0, 4'hF, rd);
    endtask

`ifdef APB_REGFILE_PSTRB_EN
    task automatic test_pstrb();
        xfer("st_wr2_full", 1'b1, 2, 32'hAABBCCDD, 4'hF, rd);
        xfer("st_wr2_part", 1'b1, 2, 32'h11223344, 4'b0101, rd);
        xfer("st_wr2_none", 1'b1, 2, 32'hFFFFFFFF, 4'b0000, rd);
        xfer("st_rd2", 1'b0, 2, 32'h0, 4'b0000, rd);
        checks++;
        if (rd !== 32'hAA22CC44) begin
            failures++;
            $display("FAIL st_rd2_value got=%h exp=aa22cc44", rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_mid_reset();
        test_psel_drop();
`ifdef APB_REGFILE_PSTRB_EN
        test_pstrb();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit");
    end
endmodule
